// File: rtl/seg_capture_if.sv
// Seven-segment capture bus: multiplexed display inputs and the captured-word outputs.
// Optional err_count member present only when SEG_CAPTURE_ERRCNT_EN is defined.
interface seg_capture_if #(
    parameter int unsigned DIGITS = 4
);
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [4*DIGITS-1:0] word_out;
    logic                word_valid;
    logic                pattern_err;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0]          err_count;

    modport master (output seg, an, input word_out, word_valid, pattern_err, err_count);
    modport slave  (input seg, an, output word_out, word_valid, pattern_err, err_count);
`else
    modport master (output seg, an, input word_out, word_valid, pattern_err);
    modport slave  (input seg, an, output word_out, word_valid, pattern_err);
`endif
endinterface

// File: rtl/seg_capture_encoder.sv
// Decodes a multiplexed active-low seven-segment bus back into a hex word once each glyph is stable.
// Optional saturating error counter enabled by defining SEG_CAPTURE_ERRCNT_EN.
module seg_capture_encoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_capture_if.slave  bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned SW = 7 + DIGITS;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SW-1:0]     s_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        digit_q [DIGITS];
    logic [DIGITS-1:0] seen_q, seen_d;
    logic [W-1:0]      word_q, word_c;
    logic              valid_q, perr_q;

    logic [SW-1:0]     sample_c;
    logic              same_c, strobe_ok_c, accept_c, hit_c, complete_c;
    logic [7:0]        low_cnt_c;
    logic [IW-1:0]     idx_c;
    logic [3:0]        nib_c;

    // Strobe is usable only when exactly one anode is driven low.
    always_comb begin
        low_cnt_c = 8'd0;
        idx_c     = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!bus.an[i]) begin
                low_cnt_c = low_cnt_c + 8'd1;
                idx_c     = IW'(i);
            end
        end
        strobe_ok_c = (low_cnt_c == 8'd1);
    end

    always_comb begin
        hit_c = 1'b1;
        nib_c = 4'h0;
        case (bus.seg)
            7'b0000001: nib_c = 4'h0;
            7'b1001111: nib_c = 4'h1;
            7'b0010010: nib_c = 4'h2;
            7'b0000110: nib_c = 4'h3;
            7'b1001100: nib_c = 4'h4;
            7'b0100100: nib_c = 4'h5;
            7'b0100000: nib_c = 4'h6;
            7'b0001111: nib_c = 4'h7;
            7'b0000000: nib_c = 4'h8;
            7'b0000100: nib_c = 4'h9;
            7'b0001000: nib_c = 4'hA;
            7'b1100000: nib_c = 4'hB;
            7'b0110001: nib_c = 4'hC;
            7'b1000010: nib_c = 4'hD;
            7'b0110000: nib_c = 4'hE;
            7'b0111000: nib_c = 4'hF;
            default:    hit_c = 1'b0;
        endcase
    end

    // Acceptance fires only on the step into the saturated count, so once per stable run.
    always_comb begin
        sample_c   = {bus.seg, bus.an};
        same_c     = (sample_c == s_q);
        accept_c   = strobe_ok_c && same_c && (cnt_q == CW'(STABLE_CYCLES - 2));
        complete_c = &seen_q;
        cnt_d      = '0;
        if (strobe_ok_c && same_c) begin
            cnt_d = (cnt_q == CW'(STABLE_CYCLES - 1)) ? cnt_q : cnt_q + CW'(1);
        end
        // Completion clears first so a same-edge acceptance lands in the next frame.
        seen_d = complete_c ? '0 : seen_q;
        if (accept_c && hit_c) begin
            seen_d[idx_c] = 1'b1;
        end
        word_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            word_c[4*i +: 4] = digit_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '1;
            cnt_q   <= '0;
            seen_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                digit_q[i] <= 4'h0;
            end
        end else begin
            s_q     <= sample_c;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            valid_q <= complete_c;
            perr_q  <= accept_c && !hit_c;
            if (complete_c) begin
                word_q <= word_c;
            end
            if (accept_c && hit_c) begin
                digit_q[idx_c] <= nib_c;
            end
        end
    end

    assign bus.word_out    = word_q;
    assign bus.word_valid  = valid_q;
    assign bus.pattern_err = perr_q;

`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else if (accept_c && !hit_c && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.err_count = err_q;
`endif
endmodule

// File: tb/tb_seg_capture_encoder.sv
// Directed bench for seg_capture_encoder (DIGITS=4, STABLE_CYCLES=4).
module tb_seg_capture_encoder;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   wv_cnt = 0;
    int   pe_cnt = 0;
    int   snap_wv, snap_pe;

    always #5 clk = ~clk;

    seg_capture_if #(.DIGITS(4)) bus ();

    seg_capture_encoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Pulse counters see each registered pulse on the edge after it appears.
    always @(posedge clk) begin
        if (bus.word_valid === 1'b1)  wv_cnt++;
        if (bus.pattern_err === 1'b1) pe_cnt++;
    end

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        bus.seg = s;
        bus.an  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.seg = 7'h7F;
        bus.an  = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (bus.word_out !== 16'h0) begin fails++; $display("FAIL reset_word_out: got %h expected 0000", bus.word_out); end
        tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL reset_word_valid: got %b expected 0", bus.word_valid); end
        tests++; if (bus.pattern_err !== 1'b0) begin fails++; $display("FAIL reset_pattern_err: got %b expected 0", bus.pattern_err); end
        tests++; if (dut.seen_q !== 4'h0) begin fails++; $display("FAIL reset_seen: got %h expected 0", dut.seen_q); end
`ifdef SEG_CAPTURE_ERRCNT_EN
        tests++; if (bus.err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count); end
`endif
    endtask

    task automatic test_single();
        snap_wv = wv_cnt;
        bus.seg = 7'b0000110;
        bus.an  = 4'b1110;
        repeat (3) @(negedge clk);
        tests++; if (dut.seen_q !== 4'h0) begin fails++; $display("FAIL single_early: got %h expected 0", dut.seen_q); end
        @(negedge clk);
        tests++; if (dut.seen_q !== 4'h1) begin fails++; $display("FAIL single_accept: got %h expected 1", dut.seen_q); end
        tests++; if (dut.digit_q[0] !== 4'h3) begin fails++; $display("FAIL single_digit0: got %h expected 3", dut.digit_q[0]); end
        repeat (6) @(negedge clk);
        tests++; if (wv_cnt - snap_wv != 0) begin fails++; $display("FAIL single_no_word: got %0d expected 0", wv_cnt - snap_wv); end
        tests++; if (dut.seen_q !== 4'h1) begin fails++; $display("FAIL single_hold: got %h expected 1", dut.seen_q); end
    endtask

    task automatic test_frame();
        snap_wv = wv_cnt;
        hold(7'b0100000, 4'b1110, 6);
        hold(7'b0001000, 4'b1101, 6);
        hold(7'b1100000, 4'b1011, 6);
        bus.seg = 7'b0111000;
        bus.an  = 4'b0111;
        repeat (4) @(negedge clk);
        tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL frame_valid_early: got %b expected 0", bus.word_valid); end
        tests++; if (dut.seen_q !== 4'hF) begin fails++; $display("FAIL frame_seen_full: got %h expected f", dut.seen_q); end
        @(negedge clk);
        tests++; if (bus.word_valid !== 1'b1) begin fails++; $display("FAIL frame_valid: got %b expected 1", bus.word_valid); end
        tests++; if (bus.word_out !== 16'hFBA6) begin fails++; $display("FAIL frame_word: got %h expected fba6", bus.word_out); end
        @(negedge clk);
        tests++; if (bus.word_valid !== 1'b0) begin fails++; $display("FAIL frame_valid_pulse: got %b expected 0", bus.word_valid); end
        tests++; if (wv_cnt - snap_wv != 1) begin fails++; $display("FAIL frame_count: got %0d expected 1", wv_cnt - snap_wv); end
        tests++; if (dut.seen_q !== 4'h0) begin fails++; $display("FAIL frame_seen_clear: got %h expected 0", dut.seen_q); end
    endtask

    task automatic test_pattern_err();
        snap_pe = pe_cnt;
        hold(7'b1111110, 4'b1101, 4);
        tests++; if (bus.pattern_err !== 1'b1) begin fails++; $display("FAIL perr_pulse: got %b expected 1", bus.pattern_err); end
        hold(7'b1111110, 4'b1101, 2);
        tests++; if (bus.pattern_err !== 1'b0) begin fails++; $display("FAIL perr_single: got %b expected 0", bus.pattern_err); end
        tests++; if (pe_cnt - snap_pe != 1) begin fails++; $display("FAIL perr_count: got %0d expected 1", pe_cnt - snap_pe); end
        tests++; if (dut.digit_q[1] !== 4'hA) begin fails++; $display("FAIL perr_digit1: got %h expected a", dut.digit_q[1]); end
        tests++; if (dut.seen_q !== 4'h0) begin fails++; $display("FAIL perr_seen: got %h expected 0", dut.seen_q); end
`ifdef SEG_CAPTURE_ERRCNT_EN
        tests++; if (bus.err_count !== 8'd1) begin fails++; $display("FAIL perr_err_count: got %0d expected 1", bus.err_count); end
`endif
    endtask

    task automatic test_unstable();
        snap_wv = wv_cnt;
        snap_pe = pe_cnt;
        for (int r = 0; r < 4; r++) begin
            hold(r[0] ? 7'b1001111 : 7'b0000001, 4'b1110, 3);
        end
        hold(7'b0000001, 4'b1100, 10);
        tests++; if (dut.seen_q !== 4'h0) begin fails++; $display("FAIL unstable_seen: got %h expected 0", dut.seen_q); end
        tests++; if (pe_cnt - snap_pe != 0) begin fails++; $display("FAIL unstable_perr: got %0d expected 0", pe_cnt - snap_pe); end
        tests++; if (wv_cnt - snap_wv != 0) begin fails++; $display("FAIL unstable_word: got %0d expected 0", wv_cnt - snap_wv); end
    endtask

    task automatic test_reset_mid();
        hold(7'b0001111, 4'b1110, 6);
        hold(7'b0001111, 4'b1101, 6);
        hold(7'b0001111, 4'b1011, 6);
        tests++; if (dut.seen_q !== 4'h7) begin fails++; $display("FAIL rmid_partial: got %h expected 7", dut.seen_q); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (dut.seen_q !== 4'h0) begin fails++; $display("FAIL rmid_seen_async: got %h expected 0", dut.seen_q); end
        tests++; if (bus.word_out !== 16'h0) begin fails++; $display("FAIL rmid_word_async: got %h expected 0000", bus.word_out); end
        @(negedge clk);
        rst_n   = 1'b1;
        snap_wv = wv_cnt;
        hold(7'b1001111, 4'b1110, 6);
        hold(7'b0010010, 4'b1101, 6);
        hold(7'b0000110, 4'b1011, 6);
        hold(7'b1001100, 4'b0111, 6);
        tests++; if (wv_cnt - snap_wv != 1) begin fails++; $display("FAIL rmid_count: got %0d expected 1", wv_cnt - snap_wv); end
        tests++; if (bus.word_out !== 16'h4321) begin fails++; $display("FAIL rmid_word: got %h expected 4321", bus.word_out); end
    endtask

    task automatic test_repeat_digit();
        snap_wv = wv_cnt;
        hold(7'b0000000, 4'b1110, 6);
        hold(7'b0110001, 4'b1101, 6);
        hold(7'b0100100, 4'b1011, 6);
        hold(7'b0000100, 4'b1011, 6);
        hold(7'b1000010, 4'b0111, 6);
        tests++; if (wv_cnt - snap_wv != 1) begin fails++; $display("FAIL repeat_count: got %0d expected 1", wv_cnt - snap_wv); end
        tests++; if (bus.word_out[11:8] !== 4'h9) begin fails++; $display("FAIL repeat_digit2: got %h expected 9", bus.word_out[11:8]); end
        tests++; if (bus.word_out !== 16'hD9C8) begin fails++; $display("FAIL repeat_word: got %h expected d9c8", bus.word_out); end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.seg = 7'h7F;
        bus.an  = 4'hF;
        @(negedge clk);
        test_reset();
        test_single();
        test_frame();
        test_pattern_err();
        test_unstable();
        test_reset_mid();
        test_repeat_digit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
